// File: rtl/adder_tree_accum_ctrl.sv
// -----------------------------------------------------------------------------
// adder_tree_accum_ctrl
//
// Sequencing controller for an external pipelined adder tree. A vector longer
// than the tree width arrives as a stream of ARRAY_SIZE-wide chunks over a
// valid/ready handshake. Each accepted chunk is driven onto the tree operands
// in the accept cycle. A {valid, last} tag follows the chunk through the
// tree's fixed latency, and the partial sums are accumulated as they emerge.
// One final sum per transaction is presented on a valid/ready output.
//
// States:
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for the first chunk; acc/count/err held cleared
//   ACCUM | accepting chunks (bubbles allowed) until the effective last one
//   FLUSH | input closed; draining in-flight tree results into acc
//   DONE  | out_valid high; sum/chunks/err held until the consumer accepts
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       chunk valid
//   in_ready       controller accepts a chunk
//   in_data        ARRAY_SIZE signed INPUT_BW-bit elements (element 0 in LSBs)
//   in_last        final chunk of the transaction
//   tree_operands  operands to the tree (in_data when accepted, else zero)
//   tree_result    signed tree sum, TREE_LATENCY cycles after the operands
//   out_valid      final sum valid
//   out_ready      consumer accepts the sum
//   out_sum        signed transaction sum
//   out_chunks     number of chunks summed in the transaction
//   out_err        transaction was force-terminated at MAX_CHUNKS chunks
// -----------------------------------------------------------------------------
module adder_tree_accum_ctrl #(
    parameter int INPUT_BW     = 8,
    parameter int ARRAY_SIZE   = 8,
    parameter int TREE_BW      = INPUT_BW + $clog2(ARRAY_SIZE),
    parameter int TREE_LATENCY = 1,
    parameter int MAX_CHUNKS   = 16,
    parameter int ACC_BW       = TREE_BW + $clog2(MAX_CHUNKS),
    parameter int CNT_BW       = $clog2(MAX_CHUNKS) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [ARRAY_SIZE-1:0][INPUT_BW-1:0]  in_data,
    input  logic                                 in_last,
    output logic [ARRAY_SIZE-1:0][INPUT_BW-1:0]  tree_operands,
    input  logic signed [TREE_BW-1:0]            tree_result,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [ACC_BW-1:0]             out_sum,
    output logic [CNT_BW-1:0]                    out_chunks,
    output logic                                 out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Held low through reset and for the first edge after release, so that
    // in_ready stays low while rst_n is asserted even though state is IDLE.
    logic run;

    logic                     in_fire;
    logic                     at_max;
    logic                     eff_last;
    logic                     forced;
    logic                     out_fire;

    logic [TREE_LATENCY-1:0]  tag_valid;
    logic [TREE_LATENCY-1:0]  tag_last;
    logic                     tail_valid;
    logic                     tail_last;

    logic signed [ACC_BW-1:0] acc;
    logic signed [ACC_BW-1:0] tree_ext;
    logic [CNT_BW-1:0]        count;
    logic                     err;

    // ------------------------------------------------------------------
    // Handshake and chunk bookkeeping
    // ------------------------------------------------------------------
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // count holds the number of chunks already accepted, so the chunk being
    // offered now is the MAX_CHUNKS-th one when count reaches MAX_CHUNKS-1.
    assign at_max   = (count == CNT_BW'(MAX_CHUNKS - 1));
    assign eff_last = in_last | at_max;
    assign forced   = in_fire & at_max & ~in_last;

    // Operands are gated to zero when nothing is accepted so the tree never
    // sees stale data; the tag pipeline ignores those results anyway.
    assign tree_operands = in_fire ? in_data : '0;

    assign tree_ext = {{(ACC_BW - TREE_BW){tree_result[TREE_BW-1]}}, tree_result};

    // ------------------------------------------------------------------
    // Tag pipeline: mirrors the tree latency so the tail marks which
    // tree_result values belong to accepted chunks.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
            tag_last  <= '0;
        end else begin
            tag_valid[0] <= in_fire;
            tag_last[0]  <= in_fire & eff_last;
            for (int i = 1; i < TREE_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_last[i]  <= tag_last[i-1];
            end
        end
    end

    assign tail_valid = tag_valid[TREE_LATENCY-1];
    assign tail_last  = tag_last[TREE_LATENCY-1];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    state_nxt = eff_last ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (in_fire && eff_last) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                // The last chunk's result is added on this same edge, so acc
                // is final by the time DONE is entered.
                if (tail_valid && tail_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_sum    = '0;
        out_chunks = '0;
        out_err    = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = run;
            end
            DONE: begin
                out_valid  = 1'b1;
                out_sum    = acc;
                out_chunks = count;
                out_err    = err;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator, beat counter and forced-termination flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else if (state == IDLE) begin
            // No results are in flight in IDLE, so acc simply stays cleared;
            // the first accepted chunk starts the count at one.
            acc   <= '0;
            count <= in_fire ? CNT_BW'(1) : '0;
            err   <= forced;
        end else if (out_fire) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (tail_valid) begin
                acc <= acc + tree_ext;
            end
            if (in_fire) begin
                count <= count + CNT_BW'(1);
            end
            if (forced) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/adder_tree_accum_ctrl.md
# adder_tree_accum_ctrl

Sequencing controller for the pipelined adder tree. It accepts a vector longer than the tree width as a stream of ARRAY_SIZE-wide chunks over a valid/ready handshake. It feeds each chunk into the external tree, tracks in-flight chunks through the tree's fixed latency, and accumulates the partial sums. It presents one final sum per transaction on a valid/ready output. It sits between the operand buffer and the result consumer, with the adder tree instantiated alongside it.

## Interface
- INPUT_BW, 8, element width (signed)
- ARRAY_SIZE, 8, elements per chunk (tree width)
- TREE_BW, 11, tree result width; equals INPUT_BW + log2(ARRAY_SIZE)
- TREE_LATENCY, 1, tree clock cycles from operands to result; must be ≥ 1
- MAX_CHUNKS, 16, maximum chunks per transaction; must be a power of 2
- ACC_BW, TREE_BW + log2(MAX_CHUNKS) = 15, accumulator/out_sum width (signed)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  chunk valid
- in_ready  out  1  controller accepts a chunk
- in_data  in  signed [INPUT_BW-1:0] x ARRAY_SIZE  chunk elements
- in_last  in  1  final chunk of the transaction
- tree_operands  out  signed [INPUT_BW-1:0] x ARRAY_SIZE  to the tree operands
- tree_result  in  signed [TREE_BW-1:0]  from the tree result
- out_valid  out  1  final sum valid
- out_ready  in  1  consumer accepts the sum
- out_sum  out  signed [ACC_BW-1:0]  transaction sum
- out_chunks  out  [log2(MAX_CHUNKS):0]  chunks summed in the transaction
- out_err  out  1  transaction was force-terminated at MAX_CHUNKS

## Operation
- in_fire = in_valid & in_ready.
- tree_operands = in_data when in_fire, else all zeros. This path is combinational, so the tree sees operands in the accept cycle.
- Tag pipeline: a TREE_LATENCY-deep shift register of {valid, last}, loaded with {in_fire, eff_last} every cycle.
  - eff_last = in_last | (beat count == MAX_CHUNKS-1).
  - The tag at the tail marks tree_result as belonging to an accepted chunk.
- Accumulate: when the tail tag is valid, acc <= acc + sign_extend(tree_result). No saturation is needed; ACC_BW covers MAX_CHUNKS full-scale chunks.
- States:
  - IDLE: in_ready=1; acc, beat count and err are cleared. in_fire → ACCUM, or → FLUSH if eff_last.
  - ACCUM: in_ready=1; one chunk per cycle is allowed. Bubbles (in_valid=0) are permitted. An in_fire with eff_last → FLUSH.
  - FLUSH: in_ready=0. When the tail tag has last=1 (its result is added that edge) → DONE.
  - DONE: in_ready=0, out_valid=1; out_sum, out_chunks and out_err are held stable. On out_valid & out_ready → IDLE, and acc, count and err are cleared.
- Beat counter: increments on in_fire; out_chunks = final count.
- Forced termination: if the MAX_CHUNKS-th beat is accepted without in_last, it is treated as last and out_err=1 for that transaction. Beats after it wait, because in_ready=0.
- Reset, including mid-transaction: state → IDLE and tags cleared, so in-flight tree results are discarded. acc, count and err are cleared.

## Timing
- Reset values:
  - in_ready=0 while rst_n=0; 1 from the first cycle after release.
  - out_valid=0, out_sum=0, out_chunks=0, out_err=0.
  - tree_operands=0.
- Latency: if the last chunk is accepted in cycle t, out_valid rises in cycle t+TREE_LATENCY+1.
- Throughput:
  - 1 chunk/cycle inside a transaction.
  - in_ready is low from the cycle after the last accept until the cycle after the output handshake.
  - The minimum gap between transactions is TREE_LATENCY+2 cycles.
- out_valid and all output data stay stable until the handshake. out_valid must not drop without out_ready.
- in_ready does not depend combinationally on in_valid. out_valid does not depend on out_ready.

## Test plan
All scenarios use the default parameters.
- Single chunk, all elements 1, in_last=1, accepted at cycle 0:
  - out_valid rises at cycle 2.
  - out_sum=8, out_chunks=1, out_err=0.
- Four back-to-back chunks, all elements -128, last on the 4th:
  - out_sum=-4096, out_chunks=4.
  - in_ready=0 from the cycle after the 4th accept.
- Bubbles: a chunk of all 127, then 3 idle cycles, then a chunk of all 1 with last:
  - out_sum=1024, out_chunks=2.
- Backpressure: out_ready held low 5 cycles in DONE:
  - out_valid stays 1 and out_sum is stable; in_ready=0 throughout.
  - After the handshake, out_valid=0 and in_ready=1 in IDLE on the next cycle.
- Forced termination: 17 chunks of all 127 offered, in_last never set:
  - Only 16 are accepted; out_sum=16256, out_chunks=16, out_err=1.
  - The 17th is accepted in IDLE after the handshake.
- Reset mid-ACCUM after 2 chunks of all 50: rst_n low 1 cycle.
  - All outputs read 0 during reset.
  - A following single chunk of all 3 with last gives out_sum=24, out_chunks=1.
